// File: rtl/l2_write_buffer.sv
// Line write-back buffer between the L1 arbiter and the cacheline adapter; coalesces, forwards, drains when idle.
// Latency: write hit/push and read hit respond 1 cycle after sampling; read miss responds 1 cycle after mem_resp_i.
// Backpressure: a write to a full buffer is held (no resp_o) until a drain pops an entry; a read miss waits for the memory port.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   read_i, write_i, address_i,   arbiter request, held until resp_o; write wins if both are high
//   line_i, line_o, resp_o        write data, read data, one-cycle completion pulse
//   mem_read_o, mem_write_o,      cacheline adapter request (never both high), line-aligned address,
//   mem_address_o, mem_line_o,    write data
//   mem_line_i, mem_resp_i        adapter read data and completion pulse
//   empty_o                       no buffered lines and no memory op in flight
module l2_write_buffer #(
    parameter int DEPTH  = 2,
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_i,
    input  logic              write_i,
    input  logic [ADDR_W-1:0] address_i,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    output logic              resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [LINE_W-1:0] mem_line_o,
    input  logic [LINE_W-1:0] mem_line_i,
    input  logic              mem_resp_i,
    output logic              empty_o
);

    localparam int TAG_W = ADDR_W - 5;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {U_IDLE, U_WFULL, U_RMISS} ustate_t;
    typedef enum logic [1:0] {M_IDLE, M_READ, M_WRITE} mstate_t;

    // Entry storage; only read where the matching valid bit is set.
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [LINE_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    ustate_t u_state, u_next;
    mstate_t m_state, m_next;

    // Request captured at sampling time, used while the request is stalled or missing.
    logic [TAG_W-1:0]  req_tag_q;
    logic [LINE_W-1:0] req_line_q;

    logic              sample;
    logic [TAG_W-1:0]  cur_tag;
    logic [LINE_W-1:0] cur_line;
    logic              draining;
    logic              wr_hit;
    logic [PTR_W-1:0]  wr_idx;
    logic              drain_hit;
    logic              wr_active;
    logic              do_coalesce;
    logic              do_push;
    logic              do_pop;
    logic              wr_stall;
    logic              rd_sample;
    logic              rd_hit;
    logic              rd_miss_new;
    logic              rd_pending;
    logic              rd_done;
    logic [LINE_W-1:0] rd_data;
    logic              addr_unused;

    assign addr_unused = ^address_i[4:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign sample    = (u_state == U_IDLE) && !resp_o && (read_i || write_i);
    assign cur_tag   = sample ? address_i[ADDR_W-1:5] : req_tag_q;
    assign cur_line  = sample ? line_i : req_line_q;
    assign draining  = (m_state == M_WRITE);

    // The entry under drain is frozen: writes never match it, so a repeat
    // write to that line lands in a fresh entry instead.
    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && tag_q[i] == cur_tag &&
                !(draining && head_q == PTR_W'(i))) begin
                wr_hit = 1'b1;
                wr_idx = PTR_W'(i);
            end
        end
    end

    assign drain_hit   = draining && (tag_q[head_q] == cur_tag);
    assign wr_active   = (sample && write_i) || (u_state == U_WFULL);
    assign do_coalesce = wr_active && wr_hit;
    assign do_push     = wr_active && !wr_hit && (count_q < CNT_W'(DEPTH));
    assign wr_stall    = wr_active && !wr_hit && (count_q >= CNT_W'(DEPTH));
    assign do_pop      = draining && mem_resp_i;

    // Reads prefer the newer non-draining copy; the draining line is the fallback.
    assign rd_sample   = sample && !write_i;
    assign rd_hit      = rd_sample && (wr_hit || drain_hit);
    assign rd_data     = wr_hit ? data_q[wr_idx] : data_q[head_q];
    assign rd_miss_new = rd_sample && !rd_hit;
    assign rd_pending  = rd_miss_new || (u_state == U_RMISS);
    assign rd_done     = (u_state == U_RMISS) && (m_state == M_READ) && mem_resp_i;

    always_comb begin
        u_next = u_state;
        unique case (u_state)
            U_IDLE:  if (wr_stall) u_next = U_WFULL;
                     else if (rd_miss_new) u_next = U_RMISS;
            U_WFULL: if (!wr_stall) u_next = U_IDLE;
            U_RMISS: if (rd_done) u_next = U_IDLE;
            default: u_next = U_IDLE;
        endcase
    end

    // A pending read miss always wins the memory port over a drain.
    always_comb begin
        m_next = m_state;
        unique case (m_state)
            M_IDLE:  if (rd_pending) m_next = M_READ;
                     else if (count_q != '0) m_next = M_WRITE;
            M_READ:  if (mem_resp_i) m_next = M_IDLE;
            M_WRITE: if (mem_resp_i) m_next = M_IDLE;
            default: m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u_state    <= U_IDLE;
            m_state    <= M_IDLE;
            resp_o     <= 1'b0;
            line_o     <= '0;
            req_tag_q  <= '0;
            req_line_q <= '0;
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            u_state <= u_next;
            m_state <= m_next;
            resp_o  <= do_coalesce || do_push || rd_hit || rd_done;
            if (rd_hit) begin
                line_o <= rd_data;
            end else if (rd_done) begin
                line_o <= mem_line_i;
            end
            if (sample) begin
                req_tag_q  <= address_i[ADDR_W-1:5];
                req_line_q <= line_i;
            end
            if (do_push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            if (do_pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: it is qualified by valid_q everywhere.
    always_ff @(posedge clk) begin
        if (do_push) begin
            tag_q[tail_q]  <= cur_tag;
            data_q[tail_q] <= cur_line;
        end else if (do_coalesce) begin
            data_q[wr_idx] <= cur_line;
        end
    end

    assign mem_read_o  = (m_state == M_READ);
    assign mem_write_o = draining;
    assign mem_line_o  = draining ? data_q[head_q] : '0;
    assign empty_o     = (count_q == '0) && (m_state == M_IDLE);

    always_comb begin
        mem_address_o = '0;
        if (draining) begin
            mem_address_o = {tag_q[head_q], 5'b0};
        end else if (m_state == M_READ) begin
            mem_address_o = {req_tag_q, 5'b0};
        end
    end

endmodule

// File: tb/tb_l2_write_buffer.sv
// Directed bench for l2_write_buffer with a queue-based reference model checked every cycle.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench); memory responses are driven manually or by a fixed-latency responder.
module tb_l2_write_buffer;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_i, write_i;
    logic [31:0]  address_i;
    logic [255:0] line_i, line_o, mem_line_o, mem_line_i;
    logic         resp_o, mem_read_o, mem_write_o, mem_resp_i, empty_o;
    logic [31:0]  mem_address_o;

    int checks   = 0;
    int failures = 0;

    logic         auto_mem  = 1'b0;
    logic         man_resp  = 1'b0;
    logic [255:0] man_line  = '0;

    l2_write_buffer #(.DEPTH(DEPTH), .LINE_W(256), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .read_i(read_i), .write_i(write_i), .address_i(address_i), .line_i(line_i),
        .line_o(line_o), .resp_o(resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_address_o(mem_address_o), .mem_line_o(mem_line_o),
        .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i),
        .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [26:0]  tag;
        logic [255:0] data;
    } ent_t;

    ent_t         mq[$];
    bit           m_drain, m_rd, m_resp;
    int           m_pend;          // 0 none, 1 stalled write, 2 read miss
    logic [31:0]  m_paddr;
    logic [255:0] m_pline, m_line;

    task automatic model_reset();
        mq.delete();
        m_drain = 0; m_rd = 0; m_resp = 0; m_pend = 0;
        m_paddr = '0; m_pline = '0; m_line = '0;
    endtask

    task automatic model_step();
        int           kind = 0;
        bit           fresh = 0;
        logic [31:0]  a = '0;
        logic [255:0] d = '0;
        int           pre_size = mq.size();
        bit           pre_drain = m_drain;
        bit           pre_rd = m_rd;
        int           first = m_drain ? 1 : 0;
        bit           push = 0, pop = 0, nresp = 0;
        int           j = -1;
        ent_t         e;
        if (m_pend == 0 && !m_resp && (write_i || read_i)) begin
            kind = write_i ? 1 : 2; a = address_i; d = line_i; fresh = 1;
        end else begin
            kind = m_pend; a = m_paddr; d = m_pline;
        end
        if (kind == 1) begin
            for (int i = first; i < pre_size; i++) if (mq[i].tag == a[31:5]) j = i;
            if (j >= 0) begin
                mq[j].data = d; nresp = 1; m_pend = 0;
            end else if (pre_size < DEPTH) begin
                push = 1; nresp = 1; m_pend = 0;
            end else begin
                m_pend = 1; m_paddr = a; m_pline = d;
            end
        end else if (kind == 2) begin
            if (fresh) begin
                for (int i = first; i < pre_size; i++) if (mq[i].tag == a[31:5]) j = i;
                if (j < 0 && pre_drain && mq[0].tag == a[31:5]) j = 0;
                if (j >= 0) begin
                    m_line = mq[j].data; nresp = 1; m_pend = 0;
                end else begin
                    m_pend = 2; m_paddr = a;
                end
            end else if (pre_rd && mem_resp_i) begin
                m_line = mem_line_i; nresp = 1; m_pend = 0;
            end
        end
        if (pre_rd) begin
            if (mem_resp_i) m_rd = 0;
        end else if (pre_drain) begin
            if (mem_resp_i) begin pop = 1; m_drain = 0; end
        end else if (m_pend == 2) begin
            m_rd = 1;
        end else if (pre_size > 0) begin
            m_drain = 1;
        end
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.tag = a[31:5]; e.data = d; mq.push_back(e);
        end
        m_resp = nresp;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cmp_resp", 256'(resp_o), 256'(m_resp));
            chk("cmp_mem_write", 256'(mem_write_o), 256'(m_drain));
            chk("cmp_mem_read", 256'(mem_read_o), 256'(m_rd));
            chk("cmp_empty", 256'(empty_o), 256'(mq.size() == 0 && !m_drain && !m_rd));
            if (m_resp) chk("cmp_line_o", line_o, m_line);
            if (m_drain && mq.size() > 0) begin
                chk("cmp_drain_addr", 256'(mem_address_o), 256'({mq[0].tag, 5'b0}));
                chk("cmp_drain_line", mem_line_o, mq[0].data);
            end
            if (m_rd) chk("cmp_read_addr", 256'(mem_address_o), 256'({m_paddr[31:5], 5'b0}));
        end
    end

    // Memory side: manual pulses, or a fixed two-cycle responder.
    initial begin
        int cnt = 0;
        mem_resp_i = 1'b0;
        mem_line_i = '0;
        forever begin
            @(negedge clk); #2;
            if (auto_mem) begin
                if (mem_resp_i) begin
                    mem_resp_i = 1'b0; cnt = 0;
                end else if (mem_read_o || mem_write_o) begin
                    cnt++;
                    if (cnt >= 2) begin
                        mem_resp_i = 1'b1;
                        mem_line_i = {8{mem_address_o ^ 32'hA5A5_0000}};
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                mem_resp_i = man_resp;
                mem_line_i = man_line;
                cnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(negedge clk); #1;
    endtask

    task automatic issue(input bit wr, input bit rd, input logic [31:0] a, input logic [255:0] d);
        write_i = wr; read_i = rd; address_i = a; line_i = d;
    endtask

    task automatic wait_resp(input string nm, input int maxc, output int n);
        n = 0;
        do begin cyc(); n++; end while (!resp_o && n < maxc);
        chk(nm, 256'(resp_o), 256'(1));
        write_i = 0; read_i = 0;
    endtask

    task automatic wait_empty(input string nm, input int maxc);
        int n = 0;
        while (!empty_o && n < maxc) begin cyc(); n++; end
        chk(nm, 256'(empty_o), 256'(1));
    endtask

    int           kinds [10] = '{1, 1, 2, 2, 1, 2, 1, 1, 1, 2};
    logic [31:0]  addrs [10] = '{32'h1000, 32'h1020, 32'h1000, 32'h2000, 32'h1004,
                                 32'h1000, 32'h3000, 32'h3020, 32'h3040, 32'h3020};

    initial begin
        int n;
        logic [255:0] d0, d1, d2, d3, x;
        d0 = {8{32'hD0D0_0000}};
        d1 = {8{32'hD1D1_1111}};
        d2 = {8{32'hD2D2_2222}};
        d3 = {8{32'hD3D3_3333}};
        x  = {8{32'h1234_5678}};
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [255:0] d0, d1, d2, d3, x;
        d0 = {8{32'hD0D0_0000}};
        d1 = {8{32'hD1D1_1111}};
        d2 = {8{32'hD2D2_2222}};
        d3 = {8{32'hD3D3_3333}};
        x  = {8{32'h1234_5678}};
        rst = 1'b1;
        issue(0, 0, '0, '0);
        repeat (3) cyc();
        chk("rst_resp", 256'(resp_o), 0);
        chk("rst_empty", 256'(empty_o), 1);
        chk("rst_mem_rw", 256'({mem_read_o, mem_write_o}), 0);
        chk("rst_line_o", line_o, 0);
        chk("rst_mem_addr", 256'(mem_address_o), 0);
        chk("rst_mem_line", mem_line_o, 0);
        rst = 1'b0;
        cyc();

        // 1: write, then drain
        issue(1, 0, 32'h100, d0);
        wait_resp("t1_resp", 10, n);
        chk("t1_resp_lat", 256'(n), 1);
        cyc();
        chk("t1_mem_write", 256'(mem_write_o), 1);
        chk("t1_mem_addr", 256'(mem_address_o), 256'(32'h100));
        chk("t1_mem_line", mem_line_o, d0);
        man_resp = 1; cyc(); man_resp = 0;
        chk("t1_popped_empty", 256'(empty_o), 1);
        chk("t1_write_drop", 256'(mem_write_o), 0);
        cyc();

        // 2: read forwarded from the buffer
        issue(1, 0, 32'h100, d0);
        wait_resp("t2_wr_resp", 10, n);
        issue(0, 1, 32'h100, '0);
        wait_resp("t2_rd_resp", 10, n);
        chk("t2_rd_lat", 256'(n), 2);
        chk("t2_line_o", line_o, d0);
        chk("t2_no_mem_read", 256'(mem_read_o), 0);
        cyc();
        chk("t2_no_mem_read2", 256'(mem_read_o), 0);
        man_resp = 1; cyc(); man_resp = 0;
        wait_empty("t2_empty", 10);

        // 3: full buffer stalls the third write
        issue(1, 0, 32'h100, d0); wait_resp("t3_w1", 10, n);
        issue(1, 0, 32'h200, d1); wait_resp("t3_w2", 10, n);
        issue(1, 0, 32'h300, d2);
        repeat (6) begin
            cyc();
            chk("t3_stall_no_resp", 256'(resp_o), 0);
        end
        man_resp = 1; cyc(); man_resp = 0;
        chk("t3_resp_not_yet", 256'(resp_o), 0);
        cyc();
        chk("t3_resp_two_later", 256'(resp_o), 1);
        issue(0, 0, '0, '0);
        auto_mem = 1;
        wait_empty("t3_empty", 40);
        auto_mem = 0;
        cyc();

        // 4: coalesce behind an in-flight drain
        issue(1, 0, 32'h100, d0); wait_resp("t4_w1", 10, n);
        issue(1, 0, 32'h200, d1); wait_resp("t4_w2", 10, n);
        issue(1, 0, 32'h200, d2); wait_resp("t4_w3_coalesce", 10, n);
        chk("t4_w3_lat", 256'(n), 2);
        chk("t4_still_draining_100", 256'(mem_address_o), 256'(32'h100));
        man_resp = 1; cyc(); man_resp = 0;
        cyc();
        chk("t4_drain2_addr", 256'(mem_address_o), 256'(32'h200));
        chk("t4_drain2_line", mem_line_o, d2);
        man_resp = 1; cyc(); man_resp = 0;
        chk("t4_empty", 256'(empty_o), 1);
        cyc();

        // 5: read miss through the adapter
        issue(0, 1, 32'h340, '0);
        cyc();
        chk("t5_mem_read", 256'(mem_read_o), 1);
        chk("t5_mem_addr", 256'(mem_address_o), 256'(32'h340));
        cyc();
        chk("t5_held", 256'(mem_read_o), 1);
        man_line = x; man_resp = 1; cyc(); man_resp = 0;
        chk("t5_resp", 256'(resp_o), 1);
        chk("t5_line_o", line_o, x);
        chk("t5_read_drop", 256'(mem_read_o), 0);
        issue(0, 0, '0, '0);
        cyc();

        // 7: read and write together -> write only
        issue(1, 1, 32'h500, d3);
        wait_resp("t7_resp", 10, n);
        chk("t7_lat", 256'(n), 1);
        cyc();
        chk("t7_no_read", 256'(mem_read_o), 0);
        chk("t7_drain_addr", 256'(mem_address_o), 256'(32'h500));
        man_resp = 1; cyc(); man_resp = 0;
        wait_empty("t7_empty", 10);

        // 6: reset in the middle of a drain
        issue(1, 0, 32'h100, d0); wait_resp("t6_w", 10, n);
        cyc();
        chk("t6_draining", 256'(mem_write_o), 1);
        rst = 1'b1; #1;
        chk("t6_rst_write", 256'(mem_write_o), 0);
        chk("t6_rst_empty", 256'(empty_o), 1);
        chk("t6_rst_outs", 256'({resp_o, mem_read_o}), 0);
        chk("t6_rst_addr", 256'(mem_address_o), 0);
        chk("t6_rst_line", mem_line_o | line_o, 0);
        #1; rst = 1'b0;
        repeat (3) begin
            cyc();
            chk("t6_op_dropped", 256'(mem_write_o), 0);
        end

        // mixed traffic with the automatic responder
        auto_mem = 1;
        for (int i = 0; i < 10; i++) begin
            issue(kinds[i] == 1, kinds[i] == 2, addrs[i], {8{32'(i) * 32'h0101_0101 + 32'hC0DE_0000}});
            wait_resp("mix_resp", 60, n);
        end
        wait_empty("mix_empty", 60);
        repeat (3) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
